// File: rtl/ks_tuning_mc_pkg.sv
// Shared defaults and helpers for the multi-channel Karplus-Strong tuning allpass.
// Q-format: samples are signed W-bit full scale; tuning is signed CW-bit with FRAC fraction bits (0.5 = 256).
package ks_tuning_mc_pkg;

  localparam int KS_W    = 24;
  localparam int KS_CW   = 10;
  localparam int KS_FRAC = 9;
  localparam int KS_CH   = 6;
  localparam int KS_SAT  = 1;

  typedef enum logic {
    KS_MODE_WRAP = 1'b0,
    KS_MODE_SAT  = 1'b1
  } ks_ovf_mode_e;

  function automatic int ks_chw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/ks_tuning_mac.sv
// Combinational tuning MAC: r = floor((tuning*d + last_in*2^FRAC) / 2^FRAC),
// with overflow detection and clamp-or-wrap to W bits.
module ks_tuning_mac
  import ks_tuning_mc_pkg::*;
#(
  parameter int W    = KS_W,
  parameter int CW   = KS_CW,
  parameter int FRAC = KS_FRAC,
  parameter int SAT  = KS_SAT
) (
  input  logic signed [CW-1:0] tuning_i,
  input  logic signed [W:0]    d_i,
  input  logic signed [W-1:0]  last_in_i,
  output logic signed [W-1:0]  out_o,
  output logic                 ovf_o
);

  localparam int PW = CW + W + 1;
  localparam int SW = CW + W + 2;
  localparam ks_ovf_mode_e MODE = (SAT != 0) ? KS_MODE_SAT : KS_MODE_WRAP;

  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] res;

  // r is representable in W bits exactly when all bits from the W-1 position up agree.
  function automatic logic fits_w(input logic signed [SW-1:0] v);
    return (&v[SW-1:W-1]) | ~(|v[SW-1:W-1]);
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [SW-1:0] v);
    return v[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  always_comb begin
    prod  = PW'(tuning_i) * PW'(d_i);
    sum   = SW'(prod) + (SW'(last_in_i) <<< FRAC);
    res   = sum >>> FRAC;
    ovf_o = ~fits_w(res);
    if ((MODE == KS_MODE_SAT) && ovf_o) begin
      out_o = sat_w(res);
    end else begin
      out_o = res[W-1:0];
    end
  end

endmodule

// File: rtl/ks_tuning_mc.sv
// Time-multiplexed tuning allpass for CH strings: out = t*in + in[-1] - t*out[-1] per channel.
// Two register stages (S1 operand capture, S2 = output register) sharing one MAC.
module ks_tuning_mc
  import ks_tuning_mc_pkg::*;
#(
  parameter  int W    = KS_W,
  parameter  int CW   = KS_CW,
  parameter  int FRAC = KS_FRAC,
  parameter  int CH   = KS_CH,
  parameter  int SAT  = KS_SAT,
  localparam int CHW  = ks_chw(CH)
) (
  input  logic                 lrck,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [W-1:0]  in_sample,
  input  logic signed [CW-1:0] tuning,
  input  logic [CH-1:0]        ch_clr,
  input  logic                 ovf_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CHW-1:0]       out_ch,
  output logic signed [W-1:0]  out_sample,
  output logic [CH-1:0]        overflow
);

  logic                 adv, s1_go, s2_go, ch_ok_p1, wr_en, fwd_hit, clr_hit;

  logic                 vld_p1_q, vld_p1_d;
  logic [CHW-1:0]       ch_p1_q, ch_p1_d;
  logic signed [W-1:0]  in_p1_q, in_p1_d;
  logic signed [W-1:0]  lin_p1_q, lin_p1_d;
  logic signed [W:0]    d_p1_q, d_p1_d;
  logic signed [CW-1:0] tun_p1_q, tun_p1_d;

  logic                 vld_p2_q, vld_p2_d;
  logic [CHW-1:0]       ch_p2_q, ch_p2_d;
  logic signed [W-1:0]  smp_p2_q, smp_p2_d;

  logic signed [W-1:0]  last_in_q  [CH];
  logic signed [W-1:0]  last_out_q [CH];
  logic [CH-1:0]        ovf_q, ovf_d;

  logic signed [W-1:0]  rf_li, rf_lo, src_li, src_lo;
  logic signed [W-1:0]  mac_out, res_p1;
  logic                 mac_ovf;

  assign adv      = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv;
  assign s1_go    = in_valid && in_ready;
  assign s2_go    = vld_p1_q && adv;
  assign ch_ok_p1 = int'(ch_p1_q) < CH;
  assign wr_en    = s2_go && ch_ok_p1;
  assign res_p1   = ch_ok_p1 ? mac_out : '0;

  ks_tuning_mac #(
    .W    (W),
    .CW   (CW),
    .FRAC (FRAC),
    .SAT  (SAT)
  ) u_mac (
    .tuning_i  (tun_p1_q),
    .d_i       (d_p1_q),
    .last_in_i (lin_p1_q),
    .out_o     (mac_out),
    .ovf_o     (mac_ovf)
  );

  // S1 operand source: a same-edge clear beats the S2 write-back, which beats the register file.
  always_comb begin
    rf_li   = '0;
    rf_lo   = '0;
    clr_hit = 1'b0;
    for (int c = 0; c < CH; c++) begin
      if (in_ch == CHW'(c)) begin
        rf_li   = last_in_q[c];
        rf_lo   = last_out_q[c];
        clr_hit = ch_clr[c];
      end
    end
    fwd_hit = wr_en && (ch_p1_q == in_ch);
    src_li  = fwd_hit ? in_p1_q : rf_li;
    src_lo  = fwd_hit ? res_p1  : rf_lo;
    if (clr_hit) begin
      src_li = '0;
      src_lo = '0;
    end
  end

  always_comb begin
    vld_p1_d = s1_go || (vld_p1_q && !adv);
    ch_p1_d  = ch_p1_q;
    in_p1_d  = in_p1_q;
    lin_p1_d = lin_p1_q;
    d_p1_d   = d_p1_q;
    tun_p1_d = tun_p1_q;
    vld_p2_d = vld_p2_q;
    ch_p2_d  = ch_p2_q;
    smp_p2_d = smp_p2_q;
    if (s1_go) begin
      ch_p1_d  = in_ch;
      in_p1_d  = in_sample;
      lin_p1_d = src_li;
      tun_p1_d = tuning;
      d_p1_d   = (W+1)'(in_sample) - (W+1)'(src_lo);
    end
    if (adv) begin
      vld_p2_d = vld_p1_q;
    end
    if (s2_go) begin
      ch_p2_d  = ch_p1_q;
      smp_p2_d = res_p1;
    end
    ovf_d = ovf_clr ? '0 : ovf_q;
    for (int c = 0; c < CH; c++) begin
      if (wr_en && mac_ovf && (ch_p1_q == CHW'(c))) begin
        ovf_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge lrck or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      ch_p1_q  <= '0;
      in_p1_q  <= '0;
      lin_p1_q <= '0;
      d_p1_q   <= '0;
      tun_p1_q <= '0;
      vld_p2_q <= 1'b0;
      ch_p2_q  <= '0;
      smp_p2_q <= '0;
      ovf_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      ch_p1_q  <= ch_p1_d;
      in_p1_q  <= in_p1_d;
      lin_p1_q <= lin_p1_d;
      d_p1_q   <= d_p1_d;
      tun_p1_q <= tun_p1_d;
      vld_p2_q <= vld_p2_d;
      ch_p2_q  <= ch_p2_d;
      smp_p2_q <= smp_p2_d;
      ovf_q    <= ovf_d;
    end
  end

  // Per-channel history; a clear on the write-back edge wins over the write.
  always_ff @(posedge lrck or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        last_in_q[c]  <= '0;
        last_out_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (ch_clr[c]) begin
          last_in_q[c]  <= '0;
          last_out_q[c] <= '0;
        end else if (wr_en && (ch_p1_q == CHW'(c))) begin
          last_in_q[c]  <= in_p1_q;
          last_out_q[c] <= res_p1;
        end
      end
    end
  end

  assign out_valid  = vld_p2_q;
  assign out_ch     = ch_p2_q;
  assign out_sample = smp_p2_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ks_tuning_mc.sv
// Bench for ks_tuning_mc: sequential per-channel reference model with an in-order
// expectation queue, directed cases with literal results, then randomized traffic.
module tb_ks_tuning_mc;

  localparam int W    = 24;
  localparam int CW   = 10;
  localparam int FRAC = 9;
  localparam int CH   = 6;
  localparam int CHW  = 3;
  localparam longint MAXV = (longint'(1) <<< (W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (W-1));

  logic                 lrck = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [CHW-1:0]       in_ch = '0;
  logic signed [W-1:0]  in_sample = '0;
  logic signed [CW-1:0] tuning = '0;
  logic [CH-1:0]        ch_clr = '0;
  logic                 ovf_clr = 1'b0;
  logic                 out_ready = 1'b1;

  logic                 in_ready, out_valid;
  logic [CHW-1:0]       out_ch;
  logic signed [W-1:0]  out_sample;
  logic [CH-1:0]        overflow;

  logic                 w_in_ready, w_out_valid;
  logic [CHW-1:0]       w_out_ch;
  logic signed [W-1:0]  w_out_sample;
  logic [CH-1:0]        w_overflow;

  always #5 lrck = ~lrck;

  ks_tuning_mc #(.W(W), .CW(CW), .FRAC(FRAC), .CH(CH), .SAT(1)) dut (
    .lrck(lrck), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_sample(in_sample), .tuning(tuning), .ch_clr(ch_clr),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_sample(out_sample), .overflow(overflow)
  );

  ks_tuning_mc #(.W(W), .CW(CW), .FRAC(FRAC), .CH(CH), .SAT(0)) u_wrap (
    .lrck(lrck), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ch(in_ch), .in_sample(in_sample), .tuning(tuning), .ch_clr(ch_clr),
    .ovf_clr(ovf_clr), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_ch(w_out_ch), .out_sample(w_out_sample), .overflow(w_overflow)
  );

  typedef struct {
    int     ch;
    longint smp;
    bit     ov;
    int     acc;
  } beat_t;

  beat_t         exp_q[$];
  longint        got_q[$];
  longint        mli[CH];
  longint        mlo[CH];
  logic [CH-1:0] mflags = '0;
  bit            head_shown = 1'b0;
  bit            took = 1'b0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Filter rule in plain integer arithmetic with floor division and clamping.
  function automatic longint ref_out(input longint t, input longint x, input longint li,
                                     input longint lo, output bit ov);
    longint den, s, q;
    den = longint'(1) << FRAC;
    s   = t * (x - lo) + li * den;
    q   = s / den;
    if ((s % den != 0) && (s < 0)) q = q - 1;
    ov = (q > MAXV) || (q < MINV);
    if (q > MAXV) return MAXV;
    if (q < MINV) return MINV;
    return q;
  endfunction

  function automatic int pending(input int c);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].ch == c) n++;
    return n;
  endfunction

  always @(negedge lrck) begin
    bit     exp_vld, exp_rdy, ov;
    longint v;
    int     ch;
    cyc++;
    took = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      for (int c = 0; c < CH; c++) begin
        mli[c] = 0;
        mlo[c] = 0;
      end
      mflags     = '0;
      head_shown = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_overflow", overflow, 0);
    end else begin
      exp_vld = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
      if (exp_vld && !head_shown) begin
        head_shown = 1'b1;
        if (exp_q[0].ov) mflags = mflags | (CH'(1) << exp_q[0].ch);
      end
      chk("out_valid", out_valid, exp_vld);
      if (exp_vld) begin
        chk("out_ch", out_ch, exp_q[0].ch);
        chk("out_sample", out_sample, exp_q[0].smp);
      end
      exp_rdy = (exp_q.size() < 2) || out_ready;
      chk("in_ready", in_ready, exp_rdy);
      chk("overflow", overflow, mflags);
      // Effects of the coming rising edge.
      if (exp_vld && out_ready) begin
        got_q.push_back(out_sample);
        void'(exp_q.pop_front());
        head_shown = 1'b0;
      end
      if (ovf_clr) mflags = '0;
      for (int c = 0; c < CH; c++) begin
        if (ch_clr[c]) begin
          mli[c] = 0;
          mlo[c] = 0;
        end
      end
      if (in_valid && exp_rdy) begin
        ch = int'(in_ch);
        ov = 1'b0;
        v  = 0;
        if (ch < CH) begin
          v = ref_out(tuning, in_sample, mli[ch], mlo[ch], ov);
          mli[ch] = in_sample;
          mlo[ch] = v;
        end
        exp_q.push_back('{ch, v, ov, cyc});
        took = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge lrck);
    #1;
  endtask

  task automatic send(input int ch, input int x, input int t);
    in_valid  = 1'b1;
    in_ch     = CHW'(ch);
    in_sample = W'(x);
    tuning    = CW'(t);
    for (int k = 0; k < 50; k++) begin
      tick();
      if (took) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++;
    failures++;
    $display("FAIL send_timeout: ch %0d not accepted within 50 cycles", ch);
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ch_clr   = '0;
    ovf_clr  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_ch", out_ch, 0);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_overflow", overflow, 0);

    // Case 1: single channel, latency and basic response.
    got_q.delete();
    send(0, 1000, 256);
    chk("t1_lat_s1", out_valid, 0);
    tick();
    chk("t1_lat_s2", out_valid, 1);
    chk("t1_first_visible", out_sample, 500);
    drain();
    send(0, 1000, 256);
    drain();
    chk("t1_count", got_q.size(), 2);
    chk("t1_out0", got_q[0], 500);
    chk("t1_out1", got_q[1], 1250);

    // Case 2: back-to-back on one channel exercises forwarding.
    got_q.delete();
    send(2, 1000, 256);
    send(2, 1000, 256);
    drain();
    chk("t2_out0", got_q[0], 500);
    chk("t2_out1", got_q[1], 1250);

    // Case 3: interleaved channels.
    ch_clr = 6'b000011;
    tick();
    ch_clr = '0;
    got_q.delete();
    send(0, 1000, 256);
    send(1, -1000, 256);
    send(0, 1000, 256);
    send(1, -1000, 256);
    drain();
    chk("t3_out0", got_q[0], 500);
    chk("t3_out1", got_q[1], -500);
    chk("t3_out2", got_q[2], 1250);
    chk("t3_out3", got_q[3], -1250);

    // Case 4: overflow, clamp vs wrap, flag clear collision.
    send(3, -8388608, -512);
    tick();
    chk("t4_sat_out", out_sample, 8388607);
    chk("t4_wrap_valid", w_out_valid, 1);
    chk("t4_wrap_ch", w_out_ch, 3);
    chk("t4_wrap_out", w_out_sample, -8388608);
    chk("t4_flag", overflow, 6'b001000);
    chk("t4_wrap_flag", w_overflow, 6'b001000);
    chk("t4_wrap_ready", w_in_ready, 1);
    drain();
    send(4, -8388608, -512);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t4_clr_vs_new", overflow, 6'b010000);
    drain();

    // Case 5: downstream stall.
    got_q.delete();
    out_ready = 1'b0;
    send(5, 100, 256);
    send(5, 100, 256);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_in_ready", in_ready, 0);
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_sample", out_sample, 50);
      tick();
    end
    out_ready = 1'b1;
    send(5, 100, 256);
    drain();
    chk("t5_count", got_q.size(), 3);
    chk("t5_out0", got_q[0], 50);
    chk("t5_out1", got_q[1], 125);
    chk("t5_out2", got_q[2], 87);

    // Case 6: channel clear between beats, then asynchronous reset mid-stream.
    do_reset();
    got_q.delete();
    send(0, 1000, 256);
    drain();
    ch_clr = 6'b000001;
    tick();
    ch_clr = '0;
    send(0, 1000, 256);
    drain();
    chk("t6_clr_out", got_q[1], 500);
    in_valid  = 1'b1;
    in_ch     = '0;
    in_sample = W'(1000);
    tuning    = CW'(256);
    tick();
    tick();
    tick();
    chk("t6_pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", out_valid, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    got_q.delete();
    send(0, 1000, 256);
    drain();
    send(0, 1000, 256);
    drain();
    chk("t6_rerun0", got_q[0], 500);
    chk("t6_rerun1", got_q[1], 1250);

    // Randomized traffic, stalls, clears and out-of-range channels.
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_ch    = CHW'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        in_sample = ($urandom_range(0, 1) == 1) ? W'(MAXV) : W'(MINV);
      end else begin
        in_sample = W'($urandom);
      end
      tuning    = CW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      ch_clr    = '0;
      for (int c = 0; c < CH; c++) begin
        if (($urandom_range(0, 19) == 0) && (pending(c) == 0) &&
            !(in_valid && (int'(in_ch) == c))) begin
          ch_clr[c] = 1'b1;
        end
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ch_clr    = '0;
    ovf_clr   = 1'b0;
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
